// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receive path: FSM encodings,
// parity-mode constants and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Total serial bits in one frame: start + data + optional parity + stop.
    function automatic int calc_nb(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on
// o_Data whenever o_Empty is low.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Push,
    input  logic             i_Pop,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Full,
    output logic             o_Empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_Full    = (r_count == DEPTH_C);
    assign o_Empty   = (r_count == '0);
    assign w_pop_ok  = i_Pop & ~o_Empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_Push & (~o_Full | w_pop_ok);
    assign o_Data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_Data;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority per bit, parity/framing
// checks, FWFT receive FIFO with sticky overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rd_En,
    input  logic                 i_Clr_Err,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Rx_Valid,
    output logic                 o_Overrun,
    output logic                 o_Busy,
    output logic                 o_Ready
);

    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int FW = DATA_BITS + 2;
    localparam logic [CW-1:0] C_SMP0 = CW'(H - 1);
    localparam logic [CW-1:0] C_SMP1 = CW'(H);
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    IDX_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    IDX_STOP_LAST = 4'(STOP_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0;
    logic                 r_s1;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;

    rx_state_t            w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [3:0]           w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_s0_nxt;
    logic                 w_s1_nxt;
    logic                 w_perr_nxt;
    logic                 w_ferr_nxt;
    logic                 w_push;
    logic                 w_rx;
    logic                 w_maj;
    logic                 w_at_dec;
    logic                 w_at_last;
    logic                 w_par_xor;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [FW-1:0]        w_head;

    assign w_rx      = r_sync2;
    // Third sample is the live input in the decision cycle.
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_at_dec  = (r_cnt == C_DEC);
    assign w_at_last = (r_cnt == C_LAST);
    assign w_par_xor = (^r_shift) ^ w_maj;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_s0_nxt    = (r_cnt == C_SMP0) ? w_rx : r_s0;
        w_s1_nxt    = (r_cnt == C_SMP1) ? w_rx : r_s1;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CW'(1);
                    w_idx_nxt   = '0;
                    w_perr_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (w_at_dec && w_maj) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_at_last) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_at_dec) begin
                    w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
                end
                if (w_at_last) begin
                    w_cnt_nxt = '0;
                    if (r_idx == IDX_DATA_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_at_dec) begin
                    w_perr_nxt = (PARITY == PAR_EVEN) ? w_par_xor : ~w_par_xor;
                end
                if (w_at_last) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            ST_STOP: begin
                if (w_at_dec) begin
                    w_ferr_nxt = r_ferr | ~w_maj;
                    // Leave mid-bit on the last stop bit so the next start edge is caught.
                    if (r_idx == IDX_STOP_LAST) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_at_last) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_sync1 <= i_Rx_Serial;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge i_Clock) begin
        r_shift <= w_shift_nxt;
        r_s0    <= w_s0_nxt;
        r_s1    <= w_s1_nxt;
        r_perr  <= w_perr_nxt;
        r_ferr  <= w_ferr_nxt;
    end

    assign w_pop  = i_Rd_En & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_Clr_Err) begin
            r_overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Push  (w_push),
        .i_Pop   (i_Rd_En),
        .i_Data  ({w_shift_nxt, r_perr, w_ferr_nxt}),
        .o_Data  (w_head),
        .o_Full  (w_full),
        .o_Empty (w_empty)
    );

    // Head fields are masked so an empty FIFO presents all-zero outputs.
    assign o_Rx_Valid   = ~w_empty;
    assign o_Rx_Byte    = o_Rx_Valid ? w_head[FW-1:2] : '0;
    assign o_Parity_Err = o_Rx_Valid & w_head[1];
    assign o_Frame_Err  = o_Rx_Valid & w_head[0];
    assign o_Overrun    = r_overrun;
    assign o_Busy       = (r_state != ST_IDLE);
    assign o_Ready      = (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four instances cover 8N1, 8E1, 8N2 and 7O2.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rx_line = 4'hF;
    logic [3:0] rd = 4'h0;
    logic [3:0] clr = 4'h0;
    logic [7:0] byte_a, byte_b, byte_c;
    logic [6:0] byte_d;
    logic [3:0] perr, ferr, valid, ovr, busy, rdy;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int rise_a = -1;
    logic prev_valid_a = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycle number at which dut A's o_Rx_Valid is first seen high after being low.
    always @(negedge clk) begin
        prev_valid_a <= valid[0];
        if (valid[0] && !prev_valid_a) rise_a <= cyc;
    end

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[0]), .i_Rd_En(rd[0]), .i_Clr_Err(clr[0]),
        .o_Rx_Byte(byte_a), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Rx_Valid(valid[0]),
        .o_Overrun(ovr[0]), .o_Busy(busy[0]), .o_Ready(rdy[0]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[1]), .i_Rd_En(rd[1]), .i_Clr_Err(clr[1]),
        .o_Rx_Byte(byte_b), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Rx_Valid(valid[1]),
        .o_Overrun(ovr[1]), .o_Busy(busy[1]), .o_Ready(rdy[1]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[2]), .i_Rd_En(rd[2]), .i_Clr_Err(clr[2]),
        .o_Rx_Byte(byte_c), .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Rx_Valid(valid[2]),
        .o_Overrun(ovr[2]), .o_Busy(busy[2]), .o_Ready(rdy[2]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_d (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[3]), .i_Rd_En(rd[3]), .i_Clr_Err(clr[3]),
        .o_Rx_Byte(byte_d), .o_Parity_Err(perr[3]), .o_Frame_Err(ferr[3]), .o_Rx_Valid(valid[3]),
        .o_Overrun(ovr[3]), .o_Busy(busy[3]), .o_Ready(rdy[3]));

    // Serial frame, bit 0 = start bit; stops[i] is the value of stop bit i.
    function automatic logic [15:0] frame(input logic [8:0] d, input int db, input int pm,
                                          input bit pflip, input int sb, input logic [1:0] stops);
        logic [15:0] f;
        int pos;
        logic p;
        f = '1;
        f[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[1 + i] = d[i];
            p = p ^ d[i];
        end
        pos = 1 + db;
        if (pm != PAR_NONE) begin
            f[pos] = ((pm == PAR_EVEN) ? p : ~p) ^ pflip;
            pos++;
        end
        for (int i = 0; i < sb; i++) f[pos + i] = stops[i];
        return f;
    endfunction

    // Drive ncyc clock cycles of a frame on line sel; t0 = cyc at the first drive.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int ncyc,
                             input int glitch_k, output int t0);
        logic v;
        t0 = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) t0 = cyc;
            v = bits[k / CPB];
            if (k == glitch_k) v = ~v;
            rx_line[sel] = v;
        end
        @(negedge clk);
        rx_line[sel] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        rd[sel] = 1'b1;
        @(negedge clk);
        rd[sel] = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);
        n_checks++;
        if ({byte_a, perr[0], ferr[0], valid[0], ovr[0], busy[0], rdy[0]} !== {8'h00, 5'b00000, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_outputs got %h required %h",
                     {byte_a, perr[0], ferr[0], valid[0], ovr[0], busy[0], rdy[0]}, {8'h00, 6'b000001});
        end
    endtask

    task automatic test_basic;
        int t0;
        int nc;
        nc = calc_nb(8, PAR_NONE, 1) * CPB;
        send_bits(0, frame(9'h0A5, 8, PAR_NONE, 0, 1, 2'b11), nc, -1, t0);
        n_checks++;
        if (rise_a !== t0 + 155) begin
            n_errors++;
            $display("FAIL valid_latency got %0d required %0d", rise_a - t0, 155);
        end
        n_checks++;
        if ({byte_a, perr[0], ferr[0]} !== {8'hA5, 2'b00}) begin
            n_errors++;
            $display("FAIL basic_a5 got %h required %h", {byte_a, perr[0], ferr[0]}, {8'hA5, 2'b00});
        end
        pop(0);
        n_checks++;
        if (valid[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_pop_empty got %b required 0", valid[0]);
        end
    endtask

    task automatic test_parity;
        int t0;
        int nc;
        nc = calc_nb(8, PAR_EVEN, 1) * CPB;
        send_bits(1, frame(9'h003, 8, PAR_EVEN, 1, 1, 2'b11), nc, -1, t0);
        idle(20);
        n_checks++;
        if ({valid[1], byte_b, perr[1], ferr[1]} !== {1'b1, 8'h03, 2'b10}) begin
            n_errors++;
            $display("FAIL parity_bad got %h required %h", {valid[1], byte_b, perr[1], ferr[1]}, {1'b1, 8'h03, 2'b10});
        end
        pop(1);
        send_bits(1, frame(9'h003, 8, PAR_EVEN, 0, 1, 2'b11), nc, -1, t0);
        idle(20);
        n_checks++;
        if ({valid[1], byte_b, perr[1], ferr[1]} !== {1'b1, 8'h03, 2'b00}) begin
            n_errors++;
            $display("FAIL parity_good got %h required %h", {valid[1], byte_b, perr[1], ferr[1]}, {1'b1, 8'h03, 2'b00});
        end
        pop(1);
    endtask

    task automatic test_framing;
        int t0;
        send_bits(0, frame(9'h05A, 8, PAR_NONE, 0, 1, 2'b00), calc_nb(8, PAR_NONE, 1) * CPB, -1, t0);
        idle(40);
        n_checks++;
        if ({valid[0], byte_a, perr[0], ferr[0]} !== {1'b1, 8'h5A, 2'b01}) begin
            n_errors++;
            $display("FAIL frame_err_1stop got %h required %h", {valid[0], byte_a, perr[0], ferr[0]}, {1'b1, 8'h5A, 2'b01});
        end
        pop(0);
        n_checks++;
        if (valid[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_err_no_extra got %b required 0", valid[0]);
        end
        send_bits(2, frame(9'h0C3, 8, PAR_NONE, 0, 2, 2'b01), calc_nb(8, PAR_NONE, 2) * CPB, -1, t0);
        idle(40);
        n_checks++;
        if ({valid[2], byte_c, ferr[2]} !== {1'b1, 8'hC3, 1'b1}) begin
            n_errors++;
            $display("FAIL frame_err_2nd_stop got %h required %h", {valid[2], byte_c, ferr[2]}, {1'b1, 8'hC3, 1'b1});
        end
        pop(2);
    endtask

    task automatic test_glitch;
        int t0;
        @(negedge clk);
        t0 = cyc;
        rx_line[0] = 1'b0;
        idle(3);
        rx_line[0] = 1'b1;
        wait_cyc(t0 + 5);
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL false_start_busy got %b required 1", busy[0]);
        end
        wait_cyc(t0 + 11);
        n_checks++;
        if ({busy[0], rdy[0]} !== 2'b01) begin
            n_errors++;
            $display("FAIL false_start_idle got %b required 01", {busy[0], rdy[0]});
        end
        idle(100);
        n_checks++;
        if (valid[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL false_start_no_push got %b required 0", valid[0]);
        end
        // Invert drive cycle c=7 of data bit 3 (frame bit 4).
        send_bits(0, frame(9'h000, 8, PAR_NONE, 0, 1, 2'b11), calc_nb(8, PAR_NONE, 1) * CPB, 4 * CPB + 7, t0);
        idle(5);
        n_checks++;
        if ({valid[0], byte_a, ferr[0]} !== {1'b1, 8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL glitch_majority got %h required %h", {valid[0], byte_a, ferr[0]}, {1'b1, 8'h00, 1'b0});
        end
        pop(0);
    endtask

    task automatic test_overrun;
        int t0;
        logic [7:0] exp_b;
        for (int i = 1; i <= 5; i++) begin
            exp_b = 8'(i * 8'h11);
            send_bits(0, frame({1'b0, exp_b}, 8, PAR_NONE, 0, 1, 2'b11), calc_nb(8, PAR_NONE, 1) * CPB, -1, t0);
            if (i == 4) begin
                n_checks++;
                if (ovr[0] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL overrun_early got %b required 0", ovr[0]);
                end
            end
        end
        idle(5);
        n_checks++;
        if (ovr[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_set got %b required 1", ovr[0]);
        end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i * 8'h11);
            n_checks++;
            if ({valid[0], byte_a} !== {1'b1, exp_b}) begin
                n_errors++;
                $display("FAIL fifo_read_%0d got %h required %h", i, {valid[0], byte_a}, {1'b1, exp_b});
            end
            pop(0);
        end
        n_checks++;
        if ({valid[0], ovr[0]} !== 2'b01) begin
            n_errors++;
            $display("FAIL fifo_drained got %b required 01", {valid[0], ovr[0]});
        end
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        n_checks++;
        if (ovr[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_clear got %b required 0", ovr[0]);
        end
    endtask

    task automatic test_back_to_back;
        int t0;
        int nc;
        logic [15:0] f;
        nc = calc_nb(7, PAR_ODD, 2) * CPB;
        f = frame(9'h041, 7, PAR_ODD, 0, 2, 2'b11);
        send_bits(3, f, nc, -1, t0);
        send_bits(3, f, nc, -1, t0);
        n_checks++;
        if ({valid[3], byte_d, perr[3], ferr[3]} !== {1'b1, 7'h41, 2'b00}) begin
            n_errors++;
            $display("FAIL b2b_first got %h required %h", {valid[3], byte_d, perr[3], ferr[3]}, {1'b1, 7'h41, 2'b00});
        end
        pop(3);
        n_checks++;
        if ({valid[3], byte_d, perr[3], ferr[3]} !== {1'b1, 7'h41, 2'b00}) begin
            n_errors++;
            $display("FAIL b2b_second got %h required %h", {valid[3], byte_d, perr[3], ferr[3]}, {1'b1, 7'h41, 2'b00});
        end
        send_bits(3, f, 5 * CPB, -1, t0);
        n_checks++;
        if (busy[3] !== 1'b1) begin
            n_errors++;
            $display("FAIL third_frame_busy got %b required 1", busy[3]);
        end
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(300);
        n_checks++;
        if ({byte_d, perr[3], ferr[3], valid[3], ovr[3], busy[3], rdy[3]} !== {7'h00, 6'b000001}) begin
            n_errors++;
            $display("FAIL mid_frame_reset got %h required %h",
                     {byte_d, perr[3], ferr[3], valid[3], ovr[3], busy[3], rdy[3]}, {7'h00, 6'b000001});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver that generalises the fixed 8N1 receive path. Configurable data width, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote. Parity and framing errors are detected per frame, and frames are buffered in a small first-word-fall-through FIFO with an overrun flag. The block sits between the serial pin and the system-side consumer (bus slave or command parser).

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit; must be >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB received first.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Rx_Serial  in  1  asynchronous serial input; idle high
i_Rd_En  in  1  pop head FIFO entry when o_Rx_Valid=1
i_Clr_Err  in  1  clears sticky o_Overrun
o_Rx_Byte  out  DATA_BITS  data of FIFO head entry
o_Parity_Err  out  1  parity error flag of head entry; 0 when PARITY=0
o_Frame_Err  out  1  framing error flag of head entry
o_Rx_Valid  out  1  FIFO not empty
o_Overrun  out  1  sticky: a frame was dropped because the FIFO was full
o_Busy  out  1  receive FSM not in IDLE
o_Ready  out  1  receive FSM in IDLE (inverse of o_Busy)

Behaviour:
- Reset (asynchronous, active-high):
  - two-flop input synchroniser set to 1; FSM to IDLE; counters 0; FIFO emptied.
  - outputs: o_Rx_Byte=0, o_Parity_Err=0, o_Frame_Err=0, o_Rx_Valid=0, o_Overrun=0, o_Busy=0, o_Ready=1.
  - reset mid-frame abandons the frame; nothing is pushed.
- Definitions: H = (CLKS_PER_BIT-1)/2 (integer). Bit counter c runs 0..CLKS_PER_BIT-1 within each bit period.
- Sampling: synced input sampled at c = H-1, H, H+1; bit value = majority of the 3 samples, decided at c = H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when the synced input is 0 (detect cycle, which counts as c=0 of the start bit) -> START with c<=1.
- START:
  - majority = 1 -> false start; return to IDLE at c=H+1.
  - majority = 0 -> DATA at c = CLKS_PER_BIT-1, bit index 0.
- DATA: shift decided bits in LSB-first. After bit DATA_BITS-1 -> PARITY if PARITY != 0, else STOP.
- PARITY: compute XOR of data bits and received parity bit.
  - even mode: error if the XOR is 1.
  - odd mode: error if the XOR is 0.
- STOP:
  - each stop bit decided 0 sets the frame error (OR across stop bits).
  - at c=H+1 of the last stop bit: push {data, perr, ferr} and return to IDLE immediately, with no wait for the end of the bit period, so back-to-back frames resynchronise.
- Push timing: push cycle = detect + (NB-1)*CLKS_PER_BIT + H + 1, where NB = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- FIFO (first-word-fall-through):
  - pushed entry drives the outputs and o_Rx_Valid from the next cycle if the FIFO was empty.
  - i_Rd_En with o_Rx_Valid=1 pops the head; next entry appears on the following cycle.
  - i_Rd_En on empty: ignored.
  - push while full and no pop in the same cycle: frame dropped, FIFO unchanged, o_Overrun<=1 on the next cycle.
  - push and pop in the same cycle while full: both succeed, no overrun.
  - push and pop in the same cycle while empty: push only; pop ignored.
  - pointers wrap modulo FIFO_DEPTH; the count register is one bit wider than the pointers.
- o_Overrun: cleared by i_Clr_Err; a new overrun in the same cycle as i_Clr_Err wins (flag stays 1).

Decomposition:
- Package uart_pkg:
  - FSM state encodings.
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - function computing NB.
- Sub-module uart_rx_fifo: synchronous FWFT FIFO, parameters WIDTH = DATA_BITS+2 and DEPTH = FIFO_DEPTH. It provides push, pop, full, empty and head data.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, send 0xA5 -> o_Rx_Valid=1 on the cycle after detect+152; o_Rx_Byte=0xA5; both error flags 0.
2. PARITY=1, send 0x03 with parity bit 1 -> o_Rx_Byte=0x03, o_Parity_Err=1. Repeat with parity bit 0 -> o_Parity_Err=0.
3. 8N1, send 0x5A with stop bit 0 -> o_Frame_Err=1, o_Rx_Byte=0x5A. STOP_BITS=2 with second stop bit 0 -> o_Frame_Err=1.
4. Idle line with a 3-cycle low pulse -> false start, FSM back in IDLE by detect+8, no push. Single-cycle glitch inverting data bit 3 at c=H of 0x00 -> o_Rx_Byte=0x00 (majority recovers).
5. FIFO_DEPTH=4, five frames 0x11..0x55 with no reads -> o_Overrun=1. Reads return 0x11, 0x22, 0x33, 0x44, then o_Rx_Valid=0. i_Clr_Err -> o_Overrun=0.
6. DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x41 with correct parity back-to-back twice. Assert i_Reset mid-third frame -> all outputs return to reset values and no third entry appears.
